// File: rtl/iter_addsub_cmp_if.sv
// Operand/request and result/flag bundle for the iterative add/subtract unit.
interface iter_addsub_cmp_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             lt;
  logic             ltu;
  logic             ne;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, lt, ltu, ne
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, lt, ltu, ne
  );
endinterface

// File: rtl/iter_addsub_cmp.sv
// Multi-cycle add/subtract with compare flags: CHUNK bits per clock,
// carry rippled through a register between slices.
module iter_addsub_cmp #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  iter_addsub_cmp_if.slave  io_bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned LAST   = NCHUNK - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;
  logic             r_lt;
  logic             r_ltu;
  logic             r_ne;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_full;
  logic             w_ovf;

  // Next-state: requests are taken only from IDLE or DONE
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(LAST)) begin
          w_next = S_DONE;
          w_last = 1'b1;
        end
      end
      S_DONE: begin
        if (io_bus.start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Current slice sum and the full result as it will stand after this edge
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_sl = r_a[k*CHUNK +: CHUNK];
        w_b_sl = r_b[k*CHUNK +: CHUNK];
      end
    end
    w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (CHUNK+1)'(r_carry);
    w_full = r_result;
    w_full[WIDTH-1 -: CHUNK] = w_sum[CHUNK-1:0];
    w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_sum[CHUNK-1] != r_a[WIDTH-1]);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_lt     <= 1'b0;
      r_ltu    <= 1'b0;
      r_ne     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
      if (w_accept) begin
        r_a     <= io_bus.a;
        r_b     <= io_bus.b ^ {WIDTH{io_bus.sub}};
        r_sub   <= io_bus.sub;
        r_carry <= io_bus.sub;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_carry <= w_sum[CHUNK];
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        for (int k = 0; k < int'(NCHUNK); k++) begin
          if (r_cnt == CW'(k)) r_result[k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
        end
        // Flags land together with the final slice
        if (w_last) begin
          r_cout <= w_sum[CHUNK];
          r_ovf  <= w_ovf;
          r_lt   <= r_sub & (w_sum[CHUNK-1] ^ w_ovf);
          r_ltu  <= r_sub & ~w_sum[CHUNK];
          r_ne   <= (|w_full) | w_ovf;
        end
      end
    end
  end

  assign io_bus.busy   = r_busy;
  assign io_bus.done   = r_done;
  assign io_bus.result = r_result;
  assign io_bus.cout   = r_cout;
  assign io_bus.ovf    = r_ovf;
  assign io_bus.lt     = r_lt;
  assign io_bus.ltu    = r_ltu;
  assign io_bus.ne     = r_ne;
endmodule

// File: tb/tb_iter_addsub_cmp.sv
// Self-checking bench for iter_addsub_cmp: directed table, random ops vs.
// an arithmetic reference, back-to-back handshake and reset-abort sequences.
module tb_iter_addsub_cmp;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned PERIOD = NCHUNK + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iter_addsub_cmp_if #(.WIDTH(WIDTH)) bus ();

  iter_addsub_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        lt;
    logic        ltu;
    logic        ne;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];
  logic [31:0] va[32];
  logic [31:0] vb[32];
  logic        vs[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output logic [31:0] res, output logic cout, output logic ovf,
                       output logic lt, output logic ltu, output logic ne);
    longint sa, sb, sr, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      res  = a - b;
      sr   = sa - sb;
      cout = (ua >= ub);
    end else begin
      res  = a + b;
      sr   = sa + sb;
      cout = ((ua + ub) > 64'sh0FFFFFFFF);
    end
    ovf = (sr > 64'sh07FFFFFFF) || (sr < -64'sh080000000);
    lt  = sub && (sa < sb);
    ltu = sub && (ua < ub);
    ne  = sub ? (a != b) : ((res != 32'd0) || ovf);
  endtask

  task automatic chk_outs(input string nm, input logic [31:0] res, input logic cout,
                          input logic ovf, input logic lt, input logic ltu, input logic ne);
    chk({nm, ".result"}, bus.result, res);
    chk({nm, ".cout"}, 32'(bus.cout), 32'(cout));
    chk({nm, ".ovf"}, 32'(bus.ovf), 32'(ovf));
    chk({nm, ".lt"}, 32'(bus.lt), 32'(lt));
    chk({nm, ".ltu"}, 32'(bus.ltu), 32'(ltu));
    chk({nm, ".ne"}, 32'(bus.ne), 32'(ne));
  endtask

  // Issue one op from IDLE; returns at the negedge where done is seen
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic sub);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.sub = sub;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.sub = 1'($urandom_range(0, 1));
    chk({nm, ".busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'(NCHUNK));
  endtask

  task automatic finish_op(input string nm, input logic [31:0] res);
    @(negedge clk);
    chk({nm, ".done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, ".idle"}, 32'(bus.busy), 32'd0);
    chk({nm, ".hold"}, bus.result, res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic co, ov, l, lu, n;
    int dcnt;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h00000009, 32'h00000009, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset, with start asserted throughout
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 32'h12345678;
    bus.b = 32'h9ABCDEF0;
    bus.sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk_outs("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("post_reset.busy", 32'(bus.busy), 32'd0);
    chk("post_reset.done", 32'(bus.done), 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub);
      chk_outs($sformatf("vec%0d", i), vecs[i].res, vecs[i].cout, vecs[i].ovf,
               vecs[i].lt, vecs[i].ltu, vecs[i].ne);
      finish_op($sformatf("vec%0d", i), vecs[i].res);
    end

    // Random ops against the reference
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      b = (i % 5 == 0) ? a : 32'($urandom);
      if (i % 7 == 3) a = 32'h80000000;
      s = 1'($urandom_range(0, 1));
      model(a, b, s, r, co, ov, l, lu, n);
      run_op($sformatf("rnd%0d", i), a, b, s);
      chk_outs($sformatf("rnd%0d", i), r, co, ov, l, lu, n);
      finish_op($sformatf("rnd%0d", i), r);
    end

    // start held high: accepted only every PERIOD cycles
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk($sformatf("b2b%0d.done", c), 32'(bus.done), 32'((c % PERIOD) == 0));
        chk($sformatf("b2b%0d.busy", c), 32'(bus.busy), 32'((c % PERIOD) != 0));
        if ((c % PERIOD) == 0) begin
          model(va[c-PERIOD], vb[c-PERIOD], vs[c-PERIOD], r, co, ov, l, lu, n);
          chk_outs($sformatf("b2b%0d", c), r, co, ov, l, lu, n);
        end
      end
      va[c] = $urandom;
      vb[c] = $urandom;
      vs[c] = 1'($urandom_range(0, 1));
      bus.start = 1'b1;
      bus.a = va[c];
      bus.b = vb[c];
      bus.sub = vs[c];
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (PERIOD + 1) @(negedge clk);
    chk("b2b.drain_busy", 32'(bus.busy), 32'd0);

    // Reset during the second RUN cycle aborts the op
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h11111111;
    bus.b = 32'h22222222;
    bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort.no_done", 32'(dcnt), 32'd0);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.result", bus.result, 32'd0);
    model(32'hDEADBEEF, 32'h0BADF00D, 1'b1, r, co, ov, l, lu, n);
    run_op("abort.fresh", 32'hDEADBEEF, 32'h0BADF00D, 1'b1);
    chk_outs("abort.fresh", r, co, ov, l, lu, n);
    finish_op("abort.fresh", r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
